// File: rtl/fifo_sync_param_pkg.sv
// Shared defaults and width helpers for the parametrised synchronous FIFO.
// Imported by the FIFO top and its dual-port memory.
package fifo_sync_param_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_AF_LEVEL = 28;
  localparam int DEF_AE_LEVEL = 4;

  // Occupancy must represent 0..DEPTH inclusive, hence DEPTH+1.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// DEPTH x DATA_W storage with one write port and one registered read port.
// The read register reads the pre-write word when both ports hit one address.
module fifo_mem_dp
  import fifo_sync_param_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // NOTE: the array has no reset so it maps onto RAM; empty/count already guard stale words.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // NOTE: non-blocking assignment keeps read-during-write returning the old word.
  always_ff @(posedge clk) begin
    if (reset)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, simultaneous read+write at the limits and sticky error flags.
module fifo_sync_param
  import fifo_sync_param_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL,
  localparam int CNT_W   = cnt_w(DEPTH),
  localparam int ADDR_W  = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow,
  output logic [1:0]        err_sticky,
  input  logic              clr_err
);

  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full, r_empty, r_almost_full, r_almost_empty;
  logic              r_rd_valid, r_overflow, r_underflow;
  logic [1:0]        r_err_sticky;

  logic              w_rd_acc, w_wr_acc, w_ovf, w_unf;
  logic [CNT_W-1:0]  w_count_nxt;

  // A read frees a slot in the same cycle, so a full FIFO can still accept a write.
  assign w_rd_acc    = read_en & ~r_empty;
  assign w_wr_acc    = write_en & (~r_full | w_rd_acc);
  assign w_ovf       = write_en & ~w_wr_acc;
  assign w_unf       = read_en & ~w_rd_acc;
  assign w_count_nxt = r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);

  fifo_mem_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (data_in),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (data_out)
  );

  // Flags are derived from the next count so they line up with count itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_rd_valid     <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
      r_err_sticky   <= 2'b00;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty        <= (w_count_nxt == '0);
      r_almost_full  <= (w_count_nxt >= CNT_W'(AF_LEVEL));
      r_almost_empty <= (w_count_nxt <= CNT_W'(AE_LEVEL));
      r_rd_valid     <= w_rd_acc;
      r_overflow     <= w_ovf;
      r_underflow    <= w_unf;
      // A new error in the clearing cycle survives the clear.
      r_err_sticky   <= (clr_err ? 2'b00 : r_err_sticky) | {w_ovf, w_unf};
    end
  end

  assign rd_valid     = r_rd_valid;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign err_sticky   = r_err_sticky;

endmodule
